uart_rx_deserializer: RTL and testbench

Receive-side serial-to-parallel stage of the APB UART. It sits between the `RX` pin and the RX FIFO write port, in the `uart_clk` domain. It oversamples the line using a one-cycle ×16 baud tick and detects start bits with majority voting. It assembles LSB-first data words, checks the stop bit and presents each frame on a valid/ready handshake to the FIFO writer, with frame-error, break and overrun reporting.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx_deserializer.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM encoding, oversampling
// defaults and the mid-bit vote window.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BRK   = 3'd4;

  localparam int VOTE_PRE  = 1;
  localparam int VOTE_POST = 1;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line.
// Flops reset to RST_VAL so the line reads idle out of reset.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (reset) ff_q <= {2{RST_VAL}};
    else       ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start detect, 2-of-3 mid-bit
// voting, LSB-first assembly and valid/ready delivery to the RX FIFO.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_x16_tick,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] C_V0   = CW'(OVERSAMPLE / 2 - VOTE_PRE);
  localparam logic [CW-1:0] C_V1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] C_V2   = CW'(OVERSAMPLE / 2 + VOTE_POST);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bitidx_q, bitidx_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [1:0]           vote_q, vote_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;
  logic                 bit_v;
  logic                 deliver;
  logic                 fe_new;

  uart_rx_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitidx_d = bitidx_q;
    sr_d     = sr_q;
    vote_d   = vote_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    fe_d     = fe_q;
    brk_d    = 1'b0;
    ovr_d    = 1'b0;
    deliver  = 1'b0;
    fe_new   = 1'b0;
    bit_v    = maj3(vote_q[0], vote_q[1], rx_s);

    if (baud_x16_tick) begin
      if (cnt_q == C_V0) vote_d[0] = rx_s;
      if (cnt_q == C_V1) vote_d[1] = rx_s;
      unique case (state_q)
        S_IDLE: begin
          if (rx_en && !rx_s) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_V2 && bit_v) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == C_LAST) begin
            state_d  = S_DATA;
            bitidx_d = '0;
          end
        end
        S_DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_V2)
            sr_d = {bit_v, sr_q[DATA_BITS-1:1]};
          if (cnt_q == C_LAST) begin
            if (bitidx_q == B_LAST) state_d = S_STOP;
            else bitidx_d = bitidx_q + 1'b1;
          end
        end
        S_STOP: begin
          cnt_d = cnt_q + 1'b1;
          // Resolve at the vote so a back-to-back start is not missed.
          if (cnt_q == C_V2) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            if (bit_v) begin
              deliver = 1'b1;
            end else if (sr_q == '0) begin
              brk_d   = 1'b1;
              state_d = S_BRK;
            end else begin
              deliver = 1'b1;
              fe_new  = 1'b1;
            end
          end
        end
        S_BRK: begin
          if (rx_s) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (!rx_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      deliver = 1'b0;
      brk_d   = 1'b0;
    end

    if (valid_q && data_ready) valid_d = 1'b0;

    // A same-cycle accept frees the slot, so the new frame replaces it.
    if (deliver) begin
      if (!valid_q || data_ready) begin
        valid_d = 1'b1;
        dout_d  = sr_q;
        fe_d    = fe_new;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitidx_q <= '0;
      sr_q     <= '0;
      vote_q   <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      fe_q     <= 1'b0;
      brk_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      sr_q     <= sr_d;
      vote_q   <= vote_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      fe_q     <= fe_d;
      brk_q    <= brk_d;
      ovr_q    <= ovr_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign frame_err  = fe_q;
  assign break_det  = brk_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: 8N1 frames at 16 clk per
// baud tick, 256 clk per bit.
module tb_uart_rx_deserializer;

  localparam int BIT_CLK = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       rx_en;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       break_det;
  logic       overrun;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  int         rises = 0;
  int         brks  = 0;
  int         ovrs  = 0;
  logic [7:0] last_data = '0;
  logic       last_fe   = 1'b0;
  logic [7:0] acc_data  = '0;
  logic       prev_v    = 1'b0;

  uart_rx_deserializer #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .baud_x16_tick(tick),
    .rx_en        (rx_en),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .frame_err    (frame_err),
    .break_det    (break_det),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    int div;
    div  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (div == 15);
      div  = (div + 1) % 16;
    end
  end

  always @(negedge clk) begin
    prev_v <= data_valid;
    if (data_valid && !prev_v) begin
      rises     <= rises + 1;
      last_data <= data_out;
      last_fe   <= frame_err;
    end
    if (data_valid && data_ready) acc_data <= data_out;
    if (break_det) brks <= brks + 1;
    if (overrun)   ovrs <= ovrs + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    wclk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wclk(BIT_CLK);
    end
    rx = stop;
    wclk(BIT_CLK);
    rx = 1'b1;
  endtask

  initial begin
    int r0, b0, o0;
    reset      = 1'b1;
    rx_en      = 1'b1;
    rx         = 1'b1;
    data_ready = 1'b1;
    wclk(4);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_fe", 32'(frame_err), 32'h0);
    chk("rst_brk", 32'(break_det), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    wclk(BIT_CLK);

    r0 = rises;
    send(8'hA5, 1'b1);
    wclk(BIT_CLK);
    chk("a5_cnt", 32'(rises - r0), 32'd1);
    chk("a5_data", 32'(last_data), 32'hA5);
    chk("a5_fe", 32'(last_fe), 32'h0);
    chk("a5_vdrop", 32'(data_valid), 32'h0);

    r0 = rises;
    rx = 1'b0;
    wclk(48);
    chk("fs_busy", 32'(busy), 32'h1);
    wclk(16);
    rx = 1'b1;
    wclk(2 * BIT_CLK);
    chk("fs_idle", 32'(busy), 32'h0);
    chk("fs_novalid", 32'(rises - r0), 32'd0);

    r0 = rises;
    send(8'h3C, 1'b0);
    wclk(2 * BIT_CLK);
    chk("fe_cnt", 32'(rises - r0), 32'd1);
    chk("fe_data", 32'(last_data), 32'h3C);
    chk("fe_flag", 32'(last_fe), 32'h1);
    chk("fe_idle", 32'(busy), 32'h0);

    r0 = rises;
    b0 = brks;
    rx = 1'b0;
    wclk(12 * BIT_CLK);
    chk("brk_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    wclk(BIT_CLK);
    chk("brk_cnt", 32'(brks - b0), 32'd1);
    chk("brk_novalid", 32'(rises - r0), 32'd0);
    chk("brk_idle", 32'(busy), 32'h0);

    r0 = rises;
    o0 = ovrs;
    data_ready = 1'b0;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    wclk(BIT_CLK);
    chk("ovr_cnt", 32'(ovrs - o0), 32'd1);
    chk("ovr_rises", 32'(rises - r0), 32'd1);
    chk("ovr_hold", 32'(data_out), 32'h11);
    chk("ovr_valid", 32'(data_valid), 32'h1);
    data_ready = 1'b1;
    wclk(2);
    chk("ovr_acc", 32'(acc_data), 32'h11);
    chk("ovr_vclr", 32'(data_valid), 32'h0);

    r0 = rises;
    rx = 1'b0;
    wclk(BIT_CLK);
    rx = 1'b1;
    wclk(2 * BIT_CLK + BIT_CLK / 2);
    rx_en = 1'b0;
    wclk(1);
    chk("en_abort", 32'(busy), 32'h0);
    rx_en = 1'b1;
    wclk(10 * BIT_CLK);
    chk("en_novalid", 32'(rises - r0), 32'd0);

    rx = 1'b0;
    wclk(BIT_CLK);
    rx = 1'b1;
    wclk(3 * BIT_CLK + BIT_CLK / 2);
    reset = 1'b1;
    wclk(2);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_data", 32'(data_out), 32'h0);
    chk("mr_valid", 32'(data_valid), 32'h0);
    reset = 1'b0;
    wclk(8 * BIT_CLK);
    r0 = rises;
    send(8'h5A, 1'b1);
    wclk(BIT_CLK);
    chk("5a_cnt", 32'(rises - r0), 32'd1);
    chk("5a_data", 32'(last_data), 32'h5A);
    chk("5a_fe", 32'(last_fe), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
